// File: rtl/dvi_ctrl_pkg.sv
// Shared types for the DVI link controller.
// State encoding doubles as the LED code on out_state.
package dvi_ctrl_pkg;

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_SETTLE    = 2'd1,
      S_BLANK     = 2'd2,
      S_ACTIVE    = 2'd3
   } state_t;

   localparam int PAT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchroniser and debouncer.
// rise pulses once on the first cycle of a new high stable level.
module btn_debounce #(
   parameter int C_debounce_bits = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic                       btn_s1;
   logic                       btn_s;
   logic                       stable;
   logic [C_debounce_bits-1:0] cnt;
   logic                       full;

   assign full = &cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1 <= 1'b0;
         btn_s  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         rise   <= 1'b0;
      end else begin
         btn_s1 <= btn;
         btn_s  <= btn_s1;
         rise   <= 1'b0;
         if (btn_s != stable) begin
            if (full) begin
               stable <= btn_s;
               cnt    <= '0;
               rise   <= btn_s;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/dvi_link_ctrl.sv
// DVI bring-up sequencer: lock settle, blanked frames, then video,
// with frame-aligned test-pattern advance from a debounced button.
module dvi_link_ctrl
   import dvi_ctrl_pkg::*;
#(
   parameter int   C_settle_cycles = 65536,
   parameter int   C_blank_frames  = 2,
   parameter int   C_debounce_bits = 18,
   parameter int   C_num_patterns  = 4,
   parameter logic C_vsync_active  = 1'b1
) (
   input  logic             clk_pixel,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             in_vsync,
   input  logic             btn_next,
   output logic             out_tmds_en,
   output logic             out_force_blank,
   output logic [PAT_W-1:0] out_pattern,
   output logic             out_frame_tick,
   output logic [1:0]       out_state
);

   localparam int SW = $clog2(C_settle_cycles);
   localparam int FW = $clog2(C_blank_frames + 1);

   state_t           state, state_n;
   logic [SW-1:0]    scnt, scnt_n;
   logic [FW-1:0]    fcnt, fcnt_n;
   logic [PAT_W-1:0] pattern, pattern_n;
   logic             pending, pending_n;
   logic             tmds_n, blank_n;
   logic             lock_s1, lock_s;
   logic             vs_q, vs_qq;
   logic             frame;
   logic             rise;

   btn_debounce #(
      .C_debounce_bits(C_debounce_bits)
   ) u_btn (
      .clk   (clk_pixel),
      .rst_n (rst_n),
      .btn   (btn_next),
      .rise  (rise)
   );

   assign frame = (vs_q == C_vsync_active) && (vs_qq != C_vsync_active);

   always_comb begin
      state_n   = state;
      scnt_n    = scnt;
      fcnt_n    = fcnt;
      pattern_n = pattern;
      pending_n = pending;
      if (rise) pending_n = 1'b1;
      unique case (state)
         S_WAIT_LOCK: begin
            scnt_n    = '0;
            fcnt_n    = '0;
            pending_n = 1'b0;
            if (lock_s) state_n = S_SETTLE;
         end
         S_SETTLE: begin
            scnt_n = scnt + 1'b1;
            if (scnt == SW'(C_settle_cycles - 1)) begin
               state_n = S_BLANK;
               fcnt_n  = '0;
            end
         end
         S_BLANK: begin
            if (frame) begin
               fcnt_n = fcnt + 1'b1;
               if (fcnt == FW'(C_blank_frames - 1)) state_n = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            // A press landing on the boundary itself waits for the next one
            if (frame && pending) begin
               if (pattern == PAT_W'(C_num_patterns - 1))
                  pattern_n = '0;
               else
                  pattern_n = pattern + 1'b1;
               if (!rise) pending_n = 1'b0;
            end
         end
      endcase
      if (!lock_s) state_n = S_WAIT_LOCK;
      tmds_n  = (state_n == S_BLANK) || (state_n == S_ACTIVE);
      blank_n = (state_n != S_ACTIVE);
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_WAIT_LOCK;
         scnt            <= '0;
         fcnt            <= '0;
         pattern         <= '0;
         pending         <= 1'b0;
         out_tmds_en     <= 1'b0;
         out_force_blank <= 1'b1;
         out_frame_tick  <= 1'b0;
         lock_s1         <= 1'b0;
         lock_s          <= 1'b0;
         vs_q            <= 1'b0;
         vs_qq           <= 1'b0;
      end else begin
         state           <= state_n;
         scnt            <= scnt_n;
         fcnt            <= fcnt_n;
         pattern         <= pattern_n;
         pending         <= pending_n;
         out_tmds_en     <= tmds_n;
         out_force_blank <= blank_n;
         out_frame_tick  <= frame;
         lock_s1         <= pll_locked;
         lock_s          <= lock_s1;
         vs_q            <= in_vsync;
         vs_qq           <= vs_q;
      end
   end

   assign out_state   = state;
   assign out_pattern = pattern;

endmodule

// File: tb/tb_dvi_link_ctrl.sv
// Directed bench for dvi_link_ctrl with a short settle/debounce setup.
module tb_dvi_link_ctrl;

   logic       clk_pixel = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       in_vsync = 1'b0;
   logic       btn_next = 1'b0;
   logic       out_tmds_en;
   logic       out_force_blank;
   logic [7:0] out_pattern;
   logic       out_frame_tick;
   logic [1:0] out_state;

   int errors = 0;
   int checks = 0;

   dvi_link_ctrl #(
      .C_settle_cycles(16),
      .C_blank_frames (2),
      .C_debounce_bits(4),
      .C_num_patterns (4),
      .C_vsync_active (1'b1)
   ) dut (
      .clk_pixel      (clk_pixel),
      .rst_n          (rst_n),
      .pll_locked     (pll_locked),
      .in_vsync       (in_vsync),
      .btn_next       (btn_next),
      .out_tmds_en    (out_tmds_en),
      .out_force_blank(out_force_blank),
      .out_pattern    (out_pattern),
      .out_frame_tick (out_frame_tick),
      .out_state      (out_state)
   );

   always #5 clk_pixel = ~clk_pixel;

   // vsync: 100-cycle period, active for 4 cycles
   initial begin
      int vcnt;
      vcnt = 50;
      forever begin
         @(negedge clk_pixel);
         vcnt = (vcnt == 99) ? 0 : vcnt + 1;
         in_vsync = (vcnt < 4);
      end
   end

   task automatic wait_state(input logic [1:0] s, input int lim,
                             output int n);
      n = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk_pixel);
         if (out_state == s) begin
            n = i + 1;
            break;
         end
      end
   endtask

   task automatic tick_wait();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk_pixel);
         if (out_frame_tick) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL tick_timeout got none want tick in 150 cycles");
      end
   endtask

   task automatic press_frame(output logic [7:0] p);
      tick_wait();
      btn_next = 1'b1;
      repeat (25) @(negedge clk_pixel);
      btn_next = 1'b0;
      tick_wait();
      p = out_pattern;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pll_locked = 1'b0;
      btn_next = 1'b0;
      repeat (3) @(negedge clk_pixel);
      checks++;
      if (out_tmds_en !== 1'b0) begin
         errors++; $display("FAIL reset_tmds got %b want 0", out_tmds_en);
      end
      checks++;
      if (out_force_blank !== 1'b1) begin
         errors++; $display("FAIL reset_blank got %b want 1", out_force_blank);
      end
      checks++;
      if (out_pattern !== 8'd0) begin
         errors++; $display("FAIL reset_pattern got %0d want 0", out_pattern);
      end
      checks++;
      if (out_frame_tick !== 1'b0) begin
         errors++; $display("FAIL reset_tick got %b want 0", out_frame_tick);
      end
      checks++;
      if (out_state !== 2'd0) begin
         errors++; $display("FAIL reset_state got %0d want 0", out_state);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk_pixel);
   endtask

   task automatic test_bringup();
      int n;
      pll_locked = 1'b1;
      wait_state(2'd1, 10, n);
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL lock_latency got %0d want 3", n);
      end
      wait_state(2'd2, 40, n);
      checks++;
      if (n != 16) begin
         errors++; $display("FAIL settle_len got %0d want 16", n);
      end
      checks++;
      if (out_tmds_en !== 1'b1 || out_force_blank !== 1'b1) begin
         errors++;
         $display("FAIL blank_outs got en=%b bl=%b want en=1 bl=1",
                  out_tmds_en, out_force_blank);
      end
      tick_wait();
      checks++;
      if (out_state !== 2'd2) begin
         errors++; $display("FAIL blank_frame1 got %0d want 2", out_state);
      end
      tick_wait();
      checks++;
      if (out_state !== 2'd3 || out_force_blank !== 1'b0 ||
          out_tmds_en !== 1'b1) begin
         errors++;
         $display("FAIL active_entry got st=%0d bl=%b en=%b want 3 0 1",
                  out_state, out_force_blank, out_tmds_en);
      end
      @(negedge clk_pixel);
      checks++;
      if (out_frame_tick !== 1'b0) begin
         errors++; $display("FAIL tick_width got %b want 0", out_frame_tick);
      end
   endtask

   task automatic test_lock_glitch();
      int n;
      pll_locked = 1'b0;
      wait_state(2'd0, 10, n);
      pll_locked = 1'b1;
      wait_state(2'd1, 10, n);
      repeat (10) @(negedge clk_pixel);
      pll_locked = 1'b0;
      @(negedge clk_pixel);
      pll_locked = 1'b1;
      wait_state(2'd0, 8, n);
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL glitch_drop got %0d want 2", n);
      end
      wait_state(2'd1, 8, n);
      checks++;
      if (n != 1) begin
         errors++; $display("FAIL glitch_relock got %0d want 1", n);
      end
      wait_state(2'd2, 40, n);
      checks++;
      if (n != 16) begin
         errors++; $display("FAIL glitch_settle got %0d want 16", n);
      end
      wait_state(2'd3, 400, n);
      checks++;
      if (n < 0) begin
         errors++; $display("FAIL glitch_active got timeout want state 3");
      end
   endtask

   task automatic test_press();
      tick_wait();
      btn_next = 1'b1;
      repeat (30) @(negedge clk_pixel);
      btn_next = 1'b0;
      checks++;
      if (out_pattern !== 8'd0) begin
         errors++; $display("FAIL press_early got %0d want 0", out_pattern);
      end
      tick_wait();
      checks++;
      if (out_pattern !== 8'd1) begin
         errors++; $display("FAIL press_adv got %0d want 1", out_pattern);
      end
      tick_wait();
      checks++;
      if (out_pattern !== 8'd1) begin
         errors++; $display("FAIL press_once got %0d want 1", out_pattern);
      end
   endtask

   task automatic test_bounce();
      tick_wait();
      for (int i = 0; i < 40; i++) begin
         btn_next = ((i / 3) % 2 == 0);
         @(negedge clk_pixel);
      end
      btn_next = 1'b0;
      tick_wait();
      tick_wait();
      checks++;
      if (out_pattern !== 8'd1) begin
         errors++; $display("FAIL bounce got %0d want 1", out_pattern);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] p;
      logic [7:0] exp [9];
      exp = '{8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
      for (int i = 0; i < 9; i++) begin
         press_frame(p);
         checks++;
         if (p !== exp[i]) begin
            errors++;
            $display("FAIL wrap_seq%0d got %0d want %0d", i, p, exp[i]);
         end
      end
   endtask

   task automatic test_lock_loss();
      int n;
      pll_locked = 1'b0;
      n = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_pixel);
         if (!out_tmds_en) begin
            n = i + 1;
            break;
         end
      end
      checks++;
      if (n < 1 || n > 3) begin
         errors++; $display("FAIL loss_tmds got %0d want <=3", n);
      end
      checks++;
      if (out_state !== 2'd0) begin
         errors++; $display("FAIL loss_state got %0d want 0", out_state);
      end
      pll_locked = 1'b1;
      wait_state(2'd3, 400, n);
      checks++;
      if (n < 0 || out_pattern !== 8'd2) begin
         errors++;
         $display("FAIL loss_keep got n=%0d pat=%0d want pat 2",
                  n, out_pattern);
      end
   endtask

   task automatic test_reset_blank();
      int n;
      pll_locked = 1'b0;
      wait_state(2'd0, 10, n);
      pll_locked = 1'b1;
      wait_state(2'd2, 40, n);
      repeat (2) @(negedge clk_pixel);
      checks++;
      if (out_state !== 2'd2) begin
         errors++; $display("FAIL mid_blank got %0d want 2", out_state);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_tmds_en !== 1'b0 || out_force_blank !== 1'b1 ||
          out_pattern !== 8'd0 || out_frame_tick !== 1'b0 ||
          out_state !== 2'd0) begin
         errors++;
         $display("FAIL async_rst got en=%b bl=%b pat=%0d tk=%b st=%0d",
                  out_tmds_en, out_force_blank, out_pattern,
                  out_frame_tick, out_state);
         $display("     want en=0 bl=1 pat=0 tk=0 st=0");
      end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_lock_glitch();
      test_press();
      test_bounce();
      test_wrap();
      test_lock_loss();
      test_reset_blank();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
